fft_addr_gen: RTL

Parametrised butterfly address generator for the in-place radix-2 FFT datapath. It is the successor of the fixed 3-bit modulus counter: two nested counters (stage, butterfly) drive a start/busy/done sequencer. It emits, per butterfly, the two memory addresses and the twiddle index for N = 2^LOG2N points, in DIT or DIF order, with a stall input. It sits between the FFT control FSM and the data/twiddle memories.

---
 rtl/fft_addr_gen.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: butterfly address generator for an in-place radix-2 FFT of N = 2^LOG2N points.
// A stage counter s and a butterfly counter b step through all (N/2)*LOG2N butterflies in
// DIT order (span 1..N/2) or DIF order (span N/2..1). The sequencer runs IDLE -> RUN -> DONE.
//
// Ports:
//   clk        in   clock, rising edge
//   sclr       in   synchronous active-high clear, highest priority
//   start      in   begin a transform (sampled only in IDLE)
//   en         in   consumer accepts the current butterfly
//   busy       out  high from the first butterfly through the DONE cycle
//   valid      out  addr_a/addr_b/tw_idx/stage hold a butterfly
//   addr_a     out  upper-leg address
//   addr_b     out  lower-leg address (addr_a + span)
//   tw_idx     out  twiddle ROM index
//   stage      out  current stage
//   stage_last out  current butterfly is the last of its stage
//   done       out  one-cycle pulse after the final butterfly is accepted
module fft_addr_gen #(
    parameter int unsigned LOG2N = 3,
    parameter bit          DIF   = 1'b0
) (
    input  logic                                                  clk,
    input  logic                                                  sclr,
    input  logic                                                  start,
    input  logic                                                  en,
    output logic                                                  busy,
    output logic                                                  valid,
    output logic [LOG2N-1:0]                                      addr_a,
    output logic [LOG2N-1:0]                                      addr_b,
    output logic [LOG2N-2:0]                                      tw_idx,
    output logic [(($clog2(LOG2N) < 1) ? 1 : $clog2(LOG2N))-1:0] stage,
    output logic                                                  stage_last,
    output logic                                                  done
);

    localparam int unsigned SW = ($clog2(LOG2N) < 1) ? 1 : $clog2(LOG2N);
    localparam int unsigned BW = LOG2N - 1;

    localparam logic [BW-1:0] B_LAST = '1;               // N/2 - 1
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [SW-1:0]    s_q, s_d;
    logic [BW-1:0]    b_q, b_d;

    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [LOG2N-1:0] addr_a_q, addr_a_d;
    logic [LOG2N-1:0] addr_b_q, addr_b_d;
    logic [BW-1:0]    tw_idx_q, tw_idx_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic             stage_last_q, stage_last_d;
    logic             done_q, done_d;

    logic             run_d;
    logic [SW-1:0]    p;
    logic [LOG2N-1:0] low_mask;
    logic [LOG2N-1:0] b_ext;
    logic [LOG2N-1:0] a_calc;

    // Sequencer and nested counters
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        b_d     = b_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    b_d     = '0;
                end
            end
            ST_RUN: begin
                if (en) begin
                    if (b_q != B_LAST) begin
                        b_d = b_q + 1'b1;
                    end else if (s_q != S_LAST) begin
                        s_d = s_q + 1'b1;
                        b_d = '0;
                    end else begin
                        state_d = ST_DONE;
                        s_d     = '0;
                        b_d     = '0;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
                b_d     = '0;
            end
        endcase
    end

    // Outputs are computed from the next counter values so they register in step with them.
    always_comb begin
        run_d    = (state_d == ST_RUN);
        p        = DIF ? (S_LAST - s_d) : s_d;    // p = log2(span)
        low_mask = (LOG2N'(1) << p) - LOG2N'(1);
        b_ext    = {1'b0, b_d};
        // Insert a zero bit at position p.
        a_calc   = ((b_ext & ~low_mask) << 1) | (b_ext & low_mask);

        busy_d       = (state_d != ST_IDLE);
        valid_d      = run_d;
        done_d       = (state_d == ST_DONE);
        addr_a_d     = run_d ? a_calc : '0;
        addr_b_d     = run_d ? (a_calc | (LOG2N'(1) << p)) : '0;
        // (b mod span) * N/(2*span): shift left by LOG2N-1-p.
        tw_idx_d     = run_d ? BW'((b_ext & low_mask) << (S_LAST - p)) : '0;
        stage_d      = run_d ? s_d : '0;
        stage_last_d = run_d && (b_d == B_LAST);
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q      <= ST_IDLE;
            s_q          <= '0;
            b_q          <= '0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            tw_idx_q     <= '0;
            stage_q      <= '0;
            stage_last_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            b_q          <= b_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            addr_a_q     <= addr_a_d;
            addr_b_q     <= addr_b_d;
            tw_idx_q     <= tw_idx_d;
            stage_q      <= stage_d;
            stage_last_q <= stage_last_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign valid      = valid_q;
    assign addr_a     = addr_a_q;
    assign addr_b     = addr_b_q;
    assign tw_idx     = tw_idx_q;
    assign stage      = stage_q;
    assign stage_last = stage_last_q;
    assign done       = done_q;

endmodule
